// File: rtl/iob_input_conditioner.sv
// iob_input_conditioner
//
// Conditions two asynchronous pad inputs (IBUF outputs) before they reach
// fabric logic. Each channel is synchronised, debounced by a stable-count
// FSM and edge-detected. A registered AND of the two debounced levels is
// also provided, since that is the function the downstream LUT consumes.
//
// Parameters
//   SYNC_STAGES   : synchroniser depth per channel (>= 2)
//   STABLE_CYCLES : consecutive mismatching samples needed to accept a new
//                   level (2..65535)
//
// Ports
//   clk               : single clock
//   rst               : synchronous, active-high reset
//   en                : debounce enable; 0 freezes the debounced levels
//   pad_a_i, pad_b_i  : asynchronous pad inputs, channels A and B
//   a_q, b_q          : debounced levels
//   and_q             : registered a_q & b_q (one cycle behind the levels)
//   a_rise, a_fall    : one-cycle pulses on a_q edges
//   b_rise, b_fall    : one-cycle pulses on b_q edges
//   and_rise          : one-cycle pulse when and_q first reads 1
//   busy              : either channel is counting a candidate level
//
// Channel index 0 is A, index 1 is B throughout.

module iob_input_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pad_a_i,
    input  logic pad_b_i,
    output logic a_q,
    output logic b_q,
    output logic and_q,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic and_rise,
    output logic busy
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q  [2];
    logic [SYNC_STAGES-1:0] sync_d  [2];
    state_e                 state_q [2];
    state_e                 state_d [2];
    logic [CW-1:0]          cnt_q   [2];
    logic [CW-1:0]          cnt_d   [2];

    logic [1:0] lvl_q, lvl_d;
    logic [1:0] rise_q, rise_d;
    logic [1:0] fall_q, fall_d;
    logic       and_lvl_q, and_lvl_d;
    logic       and_rise_q, and_rise_d;

    logic [1:0] pad_in;
    logic [1:0] s_lvl;

    assign pad_in = {pad_b_i, pad_a_i};
    // Last synchroniser stage: the only safe view of each pad.
    assign s_lvl  = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

    always_comb begin
        // The AND stage works from the registered levels, so it lags them
        // by exactly one cycle.
        and_lvl_d  = lvl_q[0] & lvl_q[1];
        and_rise_d = and_lvl_d & ~and_lvl_q;

        lvl_d  = lvl_q;
        rise_d = 2'b00;
        fall_d = 2'b00;

        for (int ch = 0; ch < 2; ch++) begin
            // The synchroniser runs regardless of en.
            sync_d[ch]  = {sync_q[ch][SYNC_STAGES-2:0], pad_in[ch]};
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];

            if (!en) begin
                // Disabling discards any partial count; level holds.
                state_d[ch] = ST_IDLE;
                cnt_d[ch]   = '0;
            end else begin
                case (state_q[ch])
                    ST_IDLE: begin
                        if (s_lvl[ch] != lvl_q[ch]) begin
                            state_d[ch] = ST_PEND;
                            cnt_d[ch]   = CW'(1);
                        end else begin
                            cnt_d[ch] = '0;
                        end
                    end
                    ST_PEND: begin
                        if (s_lvl[ch] == lvl_q[ch]) begin
                            // Glitch shorter than STABLE_CYCLES: reject.
                            state_d[ch] = ST_IDLE;
                            cnt_d[ch]   = '0;
                        end else if (cnt_q[ch] == CNT_MAX) begin
                            // This sample is the STABLE_CYCLES-th mismatch.
                            state_d[ch] = ST_IDLE;
                            cnt_d[ch]   = '0;
                            lvl_d[ch]   = s_lvl[ch];
                            rise_d[ch]  = s_lvl[ch];
                            fall_d[ch]  = ~s_lvl[ch];
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + CW'(1);
                        end
                    end
                    default: begin
                        state_d[ch] = ST_IDLE;
                        cnt_d[ch]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch]  <= '0;
                state_q[ch] <= ST_IDLE;
                cnt_q[ch]   <= '0;
            end
            lvl_q      <= 2'b00;
            rise_q     <= 2'b00;
            fall_q     <= 2'b00;
            and_lvl_q  <= 1'b0;
            and_rise_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch]  <= sync_d[ch];
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            lvl_q      <= lvl_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            and_lvl_q  <= and_lvl_d;
            and_rise_q <= and_rise_d;
        end
    end

    assign a_q      = lvl_q[0];
    assign b_q      = lvl_q[1];
    assign a_rise   = rise_q[0];
    assign a_fall   = fall_q[0];
    assign b_rise   = rise_q[1];
    assign b_fall   = fall_q[1];
    assign and_q    = and_lvl_q;
    assign and_rise = and_rise_q;
    assign busy     = (state_q[0] == ST_PEND) | (state_q[1] == ST_PEND);

endmodule

// File: tb/tb_iob_input_conditioner.sv
module tb_iob_input_conditioner;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst, en, pad_a_i, pad_b_i;
    logic a_q, b_q, and_q, a_rise, a_fall, b_rise, b_fall, and_rise, busy;

    always #5 clk = ~clk;

    iob_input_conditioner #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .pad_a_i (pad_a_i),
        .pad_b_i (pad_b_i),
        .a_q     (a_q),
        .b_q     (b_q),
        .and_q   (and_q),
        .a_rise  (a_rise),
        .a_fall  (a_fall),
        .b_rise  (b_rise),
        .b_fall  (b_fall),
        .and_rise(and_rise),
        .busy    (busy)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a level is accepted once STABLE consecutive enabled
    // samples of the synchronised pad disagree with it.
    logic [SYNC-1:0] m_sync [2];
    int              m_run  [2];
    logic [1:0]      m_q, m_rise, m_fall;
    logic            m_and, m_and_rise;

    task automatic model_edge(input logic r, input logic e, input logic pa, input logic pb);
        logic [1:0] pad;
        logic       s_old;
        logic       and_new;
        pad = {pb, pa};
        if (r) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_sync[ch] = '0;
                m_run[ch]  = 0;
            end
            m_q = 2'b00; m_rise = 2'b00; m_fall = 2'b00;
            m_and = 1'b0; m_and_rise = 1'b0;
        end else begin
            and_new    = m_q[0] & m_q[1];
            m_and_rise = and_new & ~m_and;
            m_and      = and_new;
            for (int ch = 0; ch < 2; ch++) begin
                s_old      = m_sync[ch][SYNC-1];
                m_sync[ch] = {m_sync[ch][SYNC-2:0], pad[ch]};
                m_rise[ch] = 1'b0;
                m_fall[ch] = 1'b0;
                if (e && (s_old != m_q[ch])) begin
                    m_run[ch]++;
                    if (m_run[ch] == STABLE) begin
                        m_q[ch]    = s_old;
                        m_rise[ch] = s_old;
                        m_fall[ch] = ~s_old;
                        m_run[ch]  = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    // One clock: drive inputs, predict at the edge, compare at the negedge.
    task automatic step(input logic r, input logic e, input logic pa, input logic pb);
        logic [8:0] got, exp;
        rst = r; en = e; pad_a_i = pa; pad_b_i = pb;
        @(posedge clk);
        model_edge(r, e, pa, pb);
        exp_q.push_back({(m_run[0] != 0) | (m_run[1] != 0), m_and_rise, m_and,
                         m_fall[1], m_rise[1], m_fall[0], m_rise[0], m_q[1], m_q[0]});
        @(negedge clk);
        got = {busy, and_rise, and_q, b_fall, b_rise, a_fall, a_rise, b_q, a_q};
        exp = exp_q.pop_front();
        check_eq("outs", 32'(got), 32'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first_a, first_and, fa_idx, fb_idx, and_lo_idx;
        int cnt_busy, cnt_pulse, cnt_rise;
        int hold;
        logic rp, ep, pa, pb;

        // 1. one reset cycle with pads high
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_levels", 32'({a_q, b_q, and_q}), 0);

        // 2. both pads high before edge 0: levels after edge 9, and_q after 10
        first_a = -1; first_and = -1; cnt_pulse = 0;
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            if (a_q && b_q && first_a < 0) first_a = i;
            if (and_q && first_and < 0) first_and = i;
            if (and_rise) cnt_pulse++;
        end
        check_eq("lat_ab", 32'(first_a), 9);
        check_eq("lat_and", 32'(first_and), 10);
        check_eq("and_rise_cnt", 32'(cnt_pulse), 1);

        // 6. drop both pads together
        fa_idx = -1; fb_idx = -1; and_lo_idx = -1; cnt_pulse = 0;
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (a_fall) fa_idx = i;
            if (b_fall) fb_idx = i;
            if (!and_q && and_lo_idx < 0) and_lo_idx = i;
            if (and_rise) cnt_pulse++;
        end
        check_eq("a_fall_idx", 32'(fa_idx), 9);
        check_eq("b_fall_idx", 32'(fb_idx), 9);
        check_eq("and_fall_idx", 32'(and_lo_idx), 10);
        check_eq("no_and_rise", 32'(cnt_pulse), 0);

        // 3. 7-cycle glitch on pad A is rejected
        cnt_busy = 0; cnt_rise = 0;
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, (i < 7), 1'b0);
            if (busy) cnt_busy++;
            if (a_rise) cnt_rise++;
        end
        check_eq("glitch_busy", 32'(cnt_busy), 7);
        check_eq("glitch_rise", 32'(cnt_rise), 0);
        check_eq("glitch_a_q", 32'(a_q), 0);

        // 4. pad A high while disabled, then enable
        cnt_busy = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (busy) cnt_busy++;
        end
        check_eq("dis_busy", 32'(cnt_busy), 0);
        check_eq("dis_a_q", 32'(a_q), 0);
        first_a = -1; cnt_rise = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (a_q && first_a < 0) first_a = i;
            if (a_rise) cnt_rise++;
        end
        check_eq("en_lat", 32'(first_a), 8);
        check_eq("en_rise_cnt", 32'(cnt_rise), 1);

        // 5. drop pad A, reset at PEND count 5, release with pad low
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("pend_busy", 32'(busy), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("midrst_a_q", 32'(a_q), 0);
        check_eq("midrst_a_fall", 32'(a_fall), 0);
        cnt_pulse = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            cnt_pulse += int'(a_rise) + int'(a_fall) + int'(b_rise) + int'(b_fall) + int'(and_rise);
        end
        check_eq("post_rst_pulses", 32'(cnt_pulse), 0);
        check_eq("post_rst_a_q", 32'(a_q), 0);

        // Random: held pad levels of varying length, occasional disable/reset
        hold = 0; pa = 1'b0; pb = 1'b0; ep = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                pa   = 1'($urandom_range(0, 1));
                pb   = 1'($urandom_range(0, 1));
                ep   = ($urandom_range(0, 9) != 0);
                hold = $urandom_range(1, 14);
            end
            hold--;
            rp = ($urandom_range(0, 199) == 0);
            step(rp, ep, pa, pb);
        end

        check_eq("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
